// File: rtl/tcb_pkg.sv
// Shared TCB types: port-select index, response-tracking stage and the address match rule.
package tcb_pkg;

  localparam int unsigned TCB_BN_MAX  = 16;
  localparam int unsigned TCB_DLY_MAX = 4;
  localparam int unsigned TCB_AW_MAX  = 64;
  localparam int unsigned TCB_SEL_W   = $clog2(TCB_BN_MAX);

  typedef logic [TCB_SEL_W-1:0] tcb_sel_t;

  typedef struct packed {
    logic     v;
    tcb_sel_t sel;
    logic     miss;
  } tcb_dec_stage_t;

  function automatic logic tcb_dec_match(
    input logic [TCB_AW_MAX-1:0] adr,
    input logic [TCB_AW_MAX-1:0] base,
    input logic [TCB_AW_MAX-1:0] mask
  );
    return (adr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/tcb_dec_pipe.sv
// Fixed-latency response tracker: a never-stalling DLY-deep shift register of {v, sel, miss}.
module tcb_dec_pipe
  import tcb_pkg::*;
#(
  parameter int unsigned DLY = 1
)(
  input  logic           clk,
  input  logic           rst_n,
  input  tcb_dec_stage_t d_i,
  output tcb_dec_stage_t q_o
);

  tcb_dec_stage_t stage_q [DLY];
  tcb_dec_stage_t stage_d [DLY];

  always_comb begin
    stage_d[0] = d_i;
    for (int k = 1; k < int'(DLY); k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // NOTE: every stage is reset, not just the valid bits' consumer; a stale v
  // left in any stage would surface as a phantom response after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(DLY); k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking so each stage samples its neighbour's old value.
      for (int k = 0; k < int'(DLY); k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign q_o = stage_q[DLY-1];

endmodule

// File: rtl/tcb_dec.sv
// TCB address decoder: routes one master onto BN slave ports; read data is steered
// back through a pipeline of port selects matching the fixed read latency.
module tcb_dec
  import tcb_pkg::*;
#(
  parameter int unsigned   AW  = 32,
  parameter int unsigned   DW  = 32,
  parameter int unsigned   SW  = DW/8,
  parameter int unsigned   BN  = 2,
  parameter int unsigned   DLY = 1,
  parameter logic [AW-1:0] BASE [BN] = '{32'h0000_0000, 32'h8000_0000},
  parameter logic [AW-1:0] MASK [BN] = '{32'h8000_0000, 32'h8000_0000}
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_vld,
  input  logic                   s_wen,
  input  logic [AW-1:0]          s_adr,
  input  logic [SW-1:0]          s_ben,
  input  logic [DW-1:0]          s_wdt,
  output logic [DW-1:0]          s_rdt,
  output logic                   s_rdy,
  output logic                   s_err,
  output logic [BN-1:0]          m_vld,
  output logic [BN-1:0]          m_wen,
  output logic [BN-1:0][AW-1:0]  m_adr,
  output logic [BN-1:0][SW-1:0]  m_ben,
  output logic [BN-1:0][DW-1:0]  m_wdt,
  input  logic [BN-1:0][DW-1:0]  m_rdt,
  input  logic [BN-1:0]          m_rdy
);

  if (BN < 1 || BN > TCB_BN_MAX) begin : g_chk_bn
    $fatal(1, "tcb_dec: BN must be in 1..%0d", TCB_BN_MAX);
  end
  if (DLY > TCB_DLY_MAX) begin : g_chk_dly
    $fatal(1, "tcb_dec: DLY must be in 0..%0d", TCB_DLY_MAX);
  end
  if ($size(BASE) != BN || $size(MASK) != BN) begin : g_chk_map
    $fatal(1, "tcb_dec: BASE/MASK must have BN entries");
  end
  if (AW > TCB_AW_MAX) begin : g_chk_aw
    $fatal(1, "tcb_dec: AW must not exceed %0d", TCB_AW_MAX);
  end

  tcb_sel_t       sel;
  logic           miss;
  logic           sel_rdy;
  logic           trn;
  tcb_dec_stage_t cur;
  tcb_dec_stage_t rsp;

  // Scanning from the top down lets the lowest matching port overwrite the rest.
  always_comb begin
    // NOTE: defaults first so every path assigns sel/miss and no latch is inferred.
    sel  = '0;
    miss = 1'b1;
    for (int i = int'(BN) - 1; i >= 0; i--) begin
      if (tcb_dec_match(TCB_AW_MAX'(s_adr), TCB_AW_MAX'(BASE[i]), TCB_AW_MAX'(MASK[i]))) begin
        sel  = tcb_sel_t'(i);
        miss = 1'b0;
      end
    end
  end

  always_comb begin
    sel_rdy = 1'b0;
    m_vld   = '0;
    for (int i = 0; i < int'(BN); i++) begin
      if (sel == tcb_sel_t'(i)) begin
        sel_rdy  = m_rdy[i];
        m_vld[i] = s_vld & ~miss;
      end
    end
  end

  assign m_wen = {BN{s_wen}};
  assign m_adr = {BN{s_adr}};
  assign m_ben = {BN{s_ben}};
  assign m_wdt = {BN{s_wdt}};

  // A decode miss is acknowledged at once so an unmapped access never hangs the master.
  assign s_rdy = miss | sel_rdy;
  assign trn   = s_vld & s_rdy;

  always_comb begin
    cur      = '0;
    cur.v    = trn & ~s_wen;
    cur.sel  = sel;
    cur.miss = miss;
  end

  if (DLY == 0) begin : g_rsp_comb
    assign rsp = cur;
  end else begin : g_rsp_pipe
    tcb_dec_pipe #(
      .DLY (DLY)
    ) u_pipe (
      .clk   (clk),
      .rst_n (rst),
      .d_i   (cur),
      .q_o   (rsp)
    );
  end

  always_comb begin
    s_rdt = '0;
    for (int i = 0; i < int'(BN); i++) begin
      if (rsp.v && !rsp.miss && rsp.sel == tcb_sel_t'(i)) begin
        s_rdt = m_rdt[i];
      end
    end
  end

  assign s_err = rsp.v & rsp.miss;

endmodule

// File: tb/tb_tcb_dec.sv
// Self-checking bench for tcb_dec: four decoder configurations share one stimulus stream.
module tb_tcb_dec;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int BN = 2;
  localparam int ND = 4;

  // 0: default map DLY=1, 1: sparse map with holes DLY=1, 2: default map DLY=3, 3: MASK=0 DLY=0
  localparam int DLYS [ND] = '{1, 1, 3, 0};
  localparam logic [31:0] TBASE [ND][BN] = '{
    '{32'h0000_0000, 32'h8000_0000},
    '{32'h0000_0000, 32'hFFFF_0000},
    '{32'h0000_0000, 32'h8000_0000},
    '{32'h0000_0000, 32'h8000_0000}
  };
  localparam logic [31:0] TMASK [ND][BN] = '{
    '{32'h8000_0000, 32'h8000_0000},
    '{32'hF000_0000, 32'hFFFF_0000},
    '{32'h8000_0000, 32'h8000_0000},
    '{32'h0000_0000, 32'h0000_0000}
  };

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  s_vld, s_wen;
  logic [AW-1:0]         s_adr;
  logic [SW-1:0]         s_ben;
  logic [DW-1:0]         s_wdt;
  logic [BN-1:0][DW-1:0] m_rdt;
  logic [BN-1:0]         m_rdy;

  logic [DW-1:0]         o_rdt [ND];
  logic                  o_rdy [ND];
  logic                  o_err [ND];
  logic [BN-1:0]         o_vld [ND];
  logic [BN-1:0]         o_wen [ND];
  logic [BN-1:0][AW-1:0] o_adr [ND];
  logic [BN-1:0][SW-1:0] o_ben [ND];
  logic [BN-1:0][DW-1:0] o_wdt [ND];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tcb_dec #(.DLY(1)) u_dut0 (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_wen(s_wen), .s_adr(s_adr), .s_ben(s_ben),
    .s_wdt(s_wdt), .s_rdt(o_rdt[0]), .s_rdy(o_rdy[0]), .s_err(o_err[0]), .m_vld(o_vld[0]),
    .m_wen(o_wen[0]), .m_adr(o_adr[0]), .m_ben(o_ben[0]), .m_wdt(o_wdt[0]),
    .m_rdt(m_rdt), .m_rdy(m_rdy));

  tcb_dec #(
    .DLY(1),
    .BASE('{32'h0000_0000, 32'hFFFF_0000}),
    .MASK('{32'hF000_0000, 32'hFFFF_0000})
  ) u_dut1 (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_wen(s_wen), .s_adr(s_adr), .s_ben(s_ben),
    .s_wdt(s_wdt), .s_rdt(o_rdt[1]), .s_rdy(o_rdy[1]), .s_err(o_err[1]), .m_vld(o_vld[1]),
    .m_wen(o_wen[1]), .m_adr(o_adr[1]), .m_ben(o_ben[1]), .m_wdt(o_wdt[1]),
    .m_rdt(m_rdt), .m_rdy(m_rdy));

  tcb_dec #(.DLY(3)) u_dut2 (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_wen(s_wen), .s_adr(s_adr), .s_ben(s_ben),
    .s_wdt(s_wdt), .s_rdt(o_rdt[2]), .s_rdy(o_rdy[2]), .s_err(o_err[2]), .m_vld(o_vld[2]),
    .m_wen(o_wen[2]), .m_adr(o_adr[2]), .m_ben(o_ben[2]), .m_wdt(o_wdt[2]),
    .m_rdt(m_rdt), .m_rdy(m_rdy));

  tcb_dec #(
    .DLY(0),
    .MASK('{32'h0000_0000, 32'h0000_0000})
  ) u_dut3 (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_wen(s_wen), .s_adr(s_adr), .s_ben(s_ben),
    .s_wdt(s_wdt), .s_rdt(o_rdt[3]), .s_rdy(o_rdy[3]), .s_err(o_err[3]), .m_vld(o_vld[3]),
    .m_wen(o_wen[3]), .m_adr(o_adr[3]), .m_ben(o_ben[3]), .m_wdt(o_wdt[3]),
    .m_rdt(m_rdt), .m_rdy(m_rdy));

  typedef struct {
    bit v;
    int port;
    bit miss;
  } ent_t;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_vld = 1'b0;
    s_wen = 1'b0;
    s_adr = '0;
    s_ben = '0;
    s_wdt = '0;
  endtask

  task automatic req(input bit wen, input logic [31:0] adr);
    s_vld = 1'b1;
    s_wen = wen;
    s_adr = adr;
    s_ben = '1;
    s_wdt = $urandom;
  endtask

  // First port in index order whose masked base equals the masked address.
  function automatic void tb_decode(input int k, input logic [31:0] adr,
                                    output int port, output bit miss);
    port = 0;
    miss = 1'b1;
    for (int i = 0; i < BN; i++) begin
      if (miss && ((adr & TMASK[k][i]) == (TBASE[k][i] & TMASK[k][i]))) begin
        port = i;
        miss = 1'b0;
      end
    end
  endfunction

  task automatic test_reset();
    idle();
    m_rdy = '1;
    m_rdt[0] = 32'h0101_0101;
    m_rdt[1] = 32'h0202_0202;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (o_rdt[k] !== '0) begin
        errors++;
        $display("FAIL reset_rdt dut%0d: got %h want 0", k, o_rdt[k]);
      end
      checks++;
      if (o_err[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_err dut%0d: got %b want 0", k, o_err[k]);
      end
      checks++;
      if (o_vld[k] !== 2'b00) begin
        errors++;
        $display("FAIL reset_mvld dut%0d: got %b want 00", k, o_vld[k]);
      end
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    next_cycle();
    m_rdy = '1;
    m_rdt[0] = 32'hDEAD_BEEF;
    m_rdt[1] = 32'h5555_5555;
    req(1'b0, 32'h0000_0010);
    @(negedge clk);
    checks++;
    if (o_vld[0] !== 2'b01) begin
      errors++;
      $display("FAIL single_mvld: got %b want 01", o_vld[0]);
    end
    checks++;
    if (o_rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_rdy: got %b want 1", o_rdy[0]);
    end
    checks++;
    if (o_rdt[0] !== 32'h0) begin
      errors++;
      $display("FAIL single_early: got %h want 0", o_rdt[0]);
    end
    checks++;
    if (o_rdt[3] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_dly0_rdt: got %h want deadbeef", o_rdt[3]);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (o_rdt[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_rdt: got %h want deadbeef", o_rdt[0]);
    end
    checks++;
    if (o_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_err: got %b want 0", o_err[0]);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (o_rdt[0] !== 32'h0) begin
      errors++;
      $display("FAIL single_idle: got %h want 0", o_rdt[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp2 [7];
    exp2 = '{32'h0, 32'h0, 32'h0, 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0};
    next_cycle();
    m_rdy = '1;
    m_rdt[1] = 32'h1111_1111;
    m_rdt[0] = 32'h2222_2222;
    req(1'b0, 32'h8000_0004);
    @(negedge clk);
    checks++;
    if (o_vld[0] !== 2'b10) begin
      errors++;
      $display("FAIL b2b_mvld1: got %b want 10", o_vld[0]);
    end
    next_cycle();
    req(1'b0, 32'h0000_0004);
    @(negedge clk);
    checks++;
    if (o_rdt[0] !== 32'h1111_1111) begin
      errors++;
      $display("FAIL b2b_rdt1: got %h want 11111111", o_rdt[0]);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (o_rdt[0] !== 32'h2222_2222) begin
      errors++;
      $display("FAIL b2b_rdt0: got %h want 22222222", o_rdt[0]);
    end
    for (int c = 3; c < 7; c++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if (o_rdt[2] !== exp2[c]) begin
        errors++;
        $display("FAIL b2b_dly3 cycle%0d: got %h want %h", c, o_rdt[2], exp2[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    int responses;
    responses = 0;
    next_cycle();
    m_rdy[0] = 1'b1;
    m_rdy[1] = 1'b0;
    m_rdt[1] = 32'hCAFE_F00D;
    req(1'b0, 32'h8000_0100);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (o_rdy[0] !== 1'b0 || o_vld[0] !== 2'b10) begin
        errors++;
        $display("FAIL bp_stall cycle%0d: got rdy=%b vld=%b want rdy=0 vld=10",
                 c, o_rdy[0], o_vld[0]);
      end
      if (o_rdt[0] !== '0) responses++;
      next_cycle();
    end
    m_rdy[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (o_rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got %b want 1", o_rdy[0]);
    end
    if (o_rdt[0] !== '0) responses++;
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (o_rdt[0] !== 32'hCAFE_F00D || o_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_rdt: got %h err=%b want cafef00d err=0", o_rdt[0], o_err[0]);
    end
    if (o_rdt[0] !== '0) responses++;
    next_cycle();
    @(negedge clk);
    if (o_rdt[0] !== '0) responses++;
    checks++;
    if (responses != 1) begin
      errors++;
      $display("FAIL bp_count: got %0d responses want 1", responses);
    end
  endtask

  task automatic test_decode_miss();
    next_cycle();
    m_rdy = '1;
    req(1'b0, 32'h4000_0000);
    @(negedge clk);
    checks++;
    if (o_rdy[1] !== 1'b1 || o_vld[1] !== 2'b00) begin
      errors++;
      $display("FAIL miss_req: got rdy=%b vld=%b want rdy=1 vld=00", o_rdy[1], o_vld[1]);
    end
    next_cycle();
    req(1'b1, 32'h4000_0000);
    @(negedge clk);
    checks++;
    if (o_err[1] !== 1'b1 || o_rdt[1] !== 32'h0) begin
      errors++;
      $display("FAIL miss_rsp: got err=%b rdt=%h want err=1 rdt=0", o_err[1], o_rdt[1]);
    end
    checks++;
    if (o_rdy[1] !== 1'b1 || o_vld[1] !== 2'b00) begin
      errors++;
      $display("FAIL miss_wr_req: got rdy=%b vld=%b want rdy=1 vld=00", o_rdy[1], o_vld[1]);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (o_err[1] !== 1'b0 || o_rdt[1] !== 32'h0) begin
      errors++;
      $display("FAIL miss_wr_rsp: got err=%b rdt=%h want err=0 rdt=0", o_err[1], o_rdt[1]);
    end
  endtask

  task automatic test_overlap();
    logic [DW-1:0] d0;
    d0 = $urandom;
    next_cycle();
    m_rdy = '1;
    m_rdt[0] = d0;
    m_rdt[1] = ~d0;
    req(1'b0, 32'h1234_5678);
    @(negedge clk);
    checks++;
    if (o_vld[3] !== 2'b01) begin
      errors++;
      $display("FAIL overlap_mvld: got %b want 01", o_vld[3]);
    end
    checks++;
    if (o_rdt[3] !== d0) begin
      errors++;
      $display("FAIL overlap_rdt: got %h want %h", o_rdt[3], d0);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_reset_inflight();
    next_cycle();
    m_rdy = '1;
    m_rdt[0] = 32'hAAAA_5555;
    req(1'b0, 32'h0000_0040);
    @(negedge clk);
    checks++;
    if (o_vld[2] !== 2'b01) begin
      errors++;
      $display("FAIL rstflight_mvld: got %b want 01", o_vld[2]);
    end
    next_cycle();
    idle();
    rst = 1'b0;
    for (int c = 1; c < 9; c++) begin
      if (c > 1) next_cycle();
      if (c == 3) rst = 1'b1;
      @(negedge clk);
      checks++;
      if (o_rdt[2] !== 32'h0 || o_err[2] !== 1'b0) begin
        errors++;
        $display("FAIL rstflight cycle%0d: got rdt=%h err=%b want 0/0", c, o_rdt[2], o_err[2]);
      end
    end
  endtask

  task automatic test_random();
    ent_t hist [ND][8];
    ent_t e;
    ent_t zero;
    int   port;
    bit   miss;
    bit   exp_rdy;
    logic [BN-1:0] exp_vld;
    logic [DW-1:0] exp_rdt;
    bit   exp_err;
    zero = '{v: 1'b0, port: 0, miss: 1'b0};
    for (int k = 0; k < ND; k++)
      for (int j = 0; j < 8; j++)
        hist[k][j] = zero;
    next_cycle();
    idle();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    for (int n = 0; n < 400; n++) begin
      s_vld = ($urandom_range(0, 3) != 0);
      s_wen = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0:       s_adr = {16'h0000, 16'($urandom)};
        1:       s_adr = {16'h8000, 16'($urandom)};
        2:       s_adr = {16'hFFFF, 16'($urandom)};
        3:       s_adr = {16'h4000, 16'($urandom)};
        default: s_adr = $urandom;
      endcase
      s_ben = 4'($urandom);
      s_wdt = $urandom;
      for (int i = 0; i < BN; i++) begin
        m_rdy[i] = ($urandom_range(0, 3) != 0);
        m_rdt[i] = $urandom;
      end
      @(negedge clk);
      for (int k = 0; k < ND; k++) begin
        tb_decode(k, s_adr, port, miss);
        exp_rdy = miss ? 1'b1 : m_rdy[port];
        exp_vld = (s_vld && !miss) ? BN'(1 << port) : '0;
        checks++;
        if (o_vld[k] !== exp_vld || o_rdy[k] !== exp_rdy) begin
          errors++;
          $display("FAIL rand_req dut%0d n%0d: got vld=%b rdy=%b want vld=%b rdy=%b",
                   k, n, o_vld[k], o_rdy[k], exp_vld, exp_rdy);
        end
        checks++;
        if (o_wen[k] !== {BN{s_wen}} || o_adr[k] !== {BN{s_adr}} ||
            o_ben[k] !== {BN{s_ben}} || o_wdt[k] !== {BN{s_wdt}}) begin
          errors++;
          $display("FAIL rand_bcast dut%0d n%0d: got adr=%h want %h", k, n, o_adr[k], {BN{s_adr}});
        end
        hist[k][n % 8] = '{v: s_vld && exp_rdy && !s_wen, port: port, miss: miss};
        e = (n >= DLYS[k]) ? hist[k][(n - DLYS[k]) % 8] : zero;
        exp_rdt = (e.v && !e.miss) ? m_rdt[e.port] : '0;
        exp_err = e.v && e.miss;
        checks++;
        if (o_rdt[k] !== exp_rdt || o_err[k] !== exp_err) begin
          errors++;
          $display("FAIL rand_rsp dut%0d n%0d: got rdt=%h err=%b want rdt=%h err=%b",
                   k, n, o_rdt[k], o_err[k], exp_rdt, exp_err);
        end
      end
      next_cycle();
    end
    idle();
  endtask

  initial begin
    idle();
    m_rdy = '1;
    m_rdt = '0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_backpressure();
    test_decode_miss();
    test_overlap();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
